// File: rtl/barrel_shift_reg.sv
// barrel_shift_reg
// Registered barrel rotator. The input word is rotated left or right by
// 0..WIDTH-1 positions through a log2(WIDTH)-stage mux tree, and the result
// is captured in a single WIDTH-bit output register.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears out immediately
//   in         data word to rotate
//   shift_mag  rotate amount, unsigned, 0..WIDTH-1
//   control    direction: 0 = rotate left (toward MSB), 1 = rotate right
//   out        registered rotate result, valid one cycle after sampling
//
// Flow control: there is no valid/ready handshake. Every rising edge samples
// in/shift_mag/control together and loads the result; nothing ever stalls.
// The output register is the only state in the block.

module barrel_shift_reg #(
  parameter int WIDTH   = 8,
  parameter int SHIFT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in,
  input  logic [SHIFT_W-1:0] shift_mag,
  input  logic               control,
  output logic [WIDTH-1:0]   out
);

  // Stage i rotates by 2^i when shift_mag[i] is set. Each stage owns its
  // signals so the cascade is a clean chain of separate nets rather than one
  // array that feeds back on itself.
  for (genvar i = 0; i < SHIFT_W; i++) begin : g_stage
    localparam int S = 1 << i;

    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] rot_l;
    logic [WIDTH-1:0] rot_r;
    logic [WIDTH-1:0] val;

    if (i == 0) begin : g_first
      assign src = in;
    end else begin : g_next
      assign src = g_stage[i-1].val;
    end

    // Rotations wrap the bits pushed off one end back into the other end,
    // so no bit is lost and there is no fill value.
    assign rot_l = {src[WIDTH-1-S:0], src[WIDTH-1:WIDTH-S]};
    assign rot_r = {src[S-1:0], src[WIDTH-1:S]};

    assign val = shift_mag[i] ? (control ? rot_r : rot_l) : src;
  end

  logic [WIDTH-1:0] rot_result;
  assign rot_result = g_stage[SHIFT_W-1].val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= rot_result;
    end
  end

endmodule

// File: tb/tb_barrel_shift_reg.sv
// tb_barrel_shift_reg
// Directed and streaming checks for barrel_shift_reg (WIDTH = 8).
// Inputs are driven on the falling edge; out is sampled on the falling edge,
// so every sample sees the result of the previous rising edge.

module tb_barrel_shift_reg;

  localparam int W  = 8;
  localparam int SW = 3;

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  in = '0;
  logic [SW-1:0] shift_mag = '0;
  logic          control = 1'b0;
  logic [W-1:0]  out;

  always #5 clk = ~clk;

  barrel_shift_reg #(.WIDTH(W), .SHIFT_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .shift_mag (shift_mag),
    .control   (control),
    .out       (out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: results still waiting to appear on out.
  logic [W-1:0] exp_q[$];

  // ---------------------------------------------------------------- reference
  // Bit-by-bit rotation: left moves bit b to (b+k) mod W, right takes bit b
  // from (b+k) mod W.
  function automatic logic [W-1:0] rot_model(input logic [W-1:0] a,
                                             input int k, input logic dir);
    logic [W-1:0] r;
    r = '0;
    for (int b = 0; b < W; b++) begin
      if (!dir) r[(b + k) % W] = a[b];
      else      r[b] = a[(b + k) % W];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- driver
  task automatic drive_op(input logic [W-1:0] a, input logic [SW-1:0] k,
                          input logic dir);
    in        = a;
    shift_mag = k;
    control   = dir;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    drive_op(8'hFF, 3'd5, 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_initial: out=%h expected=%h", out, 8'h00);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (out !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: out=%h expected=%h", i, out, 8'h00);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_release: out=%h expected=%h", out, 8'hFF);
    end
  endtask

  task automatic test_rotl();
    logic [W-1:0]  a_t[5]   = '{8'h7C, 8'h34, 8'h81, 8'h01, 8'hA5};
    logic [SW-1:0] k_t[5]   = '{3'd2,  3'd3,  3'd1,  3'd7,  3'd4};
    logic [W-1:0]  exp_t[5] = '{8'hF1, 8'hA1, 8'h03, 8'h80, 8'h5A};
    for (int i = 0; i < 5; i++) begin
      drive_op(a_t[i], k_t[i], 1'b0);
      @(negedge clk);
      n_checks++;
      if (out !== exp_t[i]) begin
        n_fail++;
        $display("FAIL rotl[%0d] in=%h k=%0d: out=%h expected=%h",
                 i, a_t[i], k_t[i], out, exp_t[i]);
      end
    end
  endtask

  task automatic test_rotr();
    logic [W-1:0]  a_t[5]   = '{8'h64, 8'h31, 8'h81, 8'h01, 8'hA5};
    logic [SW-1:0] k_t[5]   = '{3'd1,  3'd3,  3'd1,  3'd7,  3'd2};
    logic [W-1:0]  exp_t[5] = '{8'h32, 8'h26, 8'hC0, 8'h02, 8'h69};
    for (int i = 0; i < 5; i++) begin
      drive_op(a_t[i], k_t[i], 1'b1);
      @(negedge clk);
      n_checks++;
      if (out !== exp_t[i]) begin
        n_fail++;
        $display("FAIL rotr[%0d] in=%h k=%0d: out=%h expected=%h",
                 i, a_t[i], k_t[i], out, exp_t[i]);
      end
    end
  endtask

  task automatic test_zero_shift();
    for (int c = 0; c < 2; c++) begin
      drive_op(8'd14, 3'd0, c[0]);
      @(negedge clk);
      n_checks++;
      if (out !== 8'd14) begin
        n_fail++;
        $display("FAIL zero_shift ctl=%0d: out=%h expected=%h", c, out, 8'd14);
      end
    end
  endtask

  // Inputs changing between rising edges must not disturb out.
  task automatic test_hold_between_edges();
    drive_op(8'h0F, 3'd4, 1'b0);
    @(negedge clk);
    drive_op(8'h12, 3'd1, 1'b1);
    #2;
    n_checks++;
    if (out !== 8'hF0) begin
      n_fail++;
      $display("FAIL hold_between_edges: out=%h expected=%h", out, 8'hF0);
    end
    @(negedge clk);
    n_checks++;
    if (out !== 8'h09) begin
      n_fail++;
      $display("FAIL hold_next_load: out=%h expected=%h", out, 8'h09);
    end
  endtask

  // Every in x shift_mag x direction on consecutive cycles.
  task automatic test_back_to_back();
    logic [W-1:0] exp_v;
    exp_q.delete();
    for (int a = 0; a < 256; a++) begin
      for (int k = 0; k < 8; k++) begin
        for (int c = 0; c < 2; c++) begin
          if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if (out !== exp_v) begin
              n_fail++;
              $display("FAIL stream: out=%h expected=%h", out, exp_v);
            end
          end
          drive_op(a[W-1:0], k[SW-1:0], c[0]);
          exp_q.push_back(rot_model(a[W-1:0], k, c[0]));
          @(negedge clk);
        end
      end
    end
    exp_v = exp_q.pop_front();
    n_checks++;
    if (out !== exp_v) begin
      n_fail++;
      $display("FAIL stream_last: out=%h expected=%h", out, exp_v);
    end
  endtask

  // rotl k then rotr k of the rotated value must restore the original word.
  task automatic test_round_trip();
    logic [W-1:0] a_t[4] = '{8'h5B, 8'hC3, 8'h01, 8'hE4};
    logic [W-1:0] mid;
    for (int i = 0; i < 4; i++) begin
      for (int k = 1; k < 8; k++) begin
        drive_op(a_t[i], k[SW-1:0], 1'b0);
        @(negedge clk);
        mid = out;
        n_checks++;
        if (mid !== rot_model(a_t[i], k, 1'b0)) begin
          n_fail++;
          $display("FAIL round_trip_left in=%h k=%0d: out=%h expected=%h",
                   a_t[i], k, mid, rot_model(a_t[i], k, 1'b0));
        end
        drive_op(mid, k[SW-1:0], 1'b1);
        @(negedge clk);
        n_checks++;
        if (out !== a_t[i]) begin
          n_fail++;
          $display("FAIL round_trip_back in=%h k=%0d: out=%h expected=%h",
                   a_t[i], k, out, a_t[i]);
        end
      end
    end
  endtask

  // Asynchronous reset mid-stream: out clears at once, then resumes.
  task automatic test_mid_reset();
    drive_op(8'h96, 3'd3, 1'b0);
    @(negedge clk);
    n_checks++;
    if (out !== 8'hB4) begin
      n_fail++;
      $display("FAIL mid_reset_pre: out=%h expected=%h", out, 8'hB4);
    end
    drive_op(8'h3C, 3'd2, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset_async: out=%h expected=%h", out, 8'h00);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (out !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset_held: out=%h expected=%h", out, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_op(8'h3C, 3'd2, 1'b1);
    @(negedge clk);
    n_checks++;
    if (out !== 8'h0F) begin
      n_fail++;
      $display("FAIL mid_reset_resume: out=%h expected=%h", out, 8'h0F);
    end
    drive_op(8'h3C, 3'd6, 1'b0);
    @(negedge clk);
    n_checks++;
    if (out !== 8'h0F) begin
      n_fail++;
      $display("FAIL mid_reset_resume2: out=%h expected=%h", out, 8'h0F);
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_rotl();
    test_rotr();
    test_zero_shift();
    test_hold_between_edges();
    test_back_to_back();
    test_round_trip();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
